// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_resp_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_resp_arbiter.sv
// Grant selection between fetch and data ports; fixed data priority by default,
// round-robin on ties when MEM_RESP_FAIR_ARB_EN is defined.
module mem_resp_arbiter
    import mem_resp_pkg::*;
(
    input  logic  clk,
    input  logic  nRST,
    input  logic  idle,
    input  logic  i_req,
    input  logic  d_req,
    output logic  gnt_valid,
    output port_t gnt_port
);

    assign gnt_valid = i_req | d_req;

`ifdef MEM_RESP_FAIR_ARB_EN
    port_t last_q;

    // Starts as "data" so the first tie goes to fetch.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            last_q <= PORT_D;
        end else if (idle && gnt_valid) begin
            last_q <= gnt_port;
        end
    end

    always_comb begin
        gnt_port = PORT_I;
        if (i_req && d_req) begin
            gnt_port = (last_q == PORT_D) ? PORT_I : PORT_D;
        end else if (d_req) begin
            gnt_port = PORT_D;
        end
    end
`else
    logic unused;

    assign gnt_port = d_req ? PORT_D : PORT_I;
    assign unused   = &{1'b0, clk, nRST, idle};
`endif

endmodule

// File: rtl/mem_responder.sv
// Arbitrates fetch and load/store requests onto a fixed-latency single-port RAM.
// Optional round-robin arbitration: define MEM_RESP_FAIR_ARB_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [DW-1:0]     i_rdata,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [31:0]       d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic [DW-1:0]     d_rdata,
    output logic              d_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output state_t            dbg_state
);

    // Handshake: a port holds its request level until it sees its one-cycle
    // ready pulse; requests are sampled only when the FSM grants in IDLE.
    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    port_t             port_q;
    op_t               op_q;
    logic              d_req, gnt_valid, gnt_wr, take, done;
    port_t             gnt_port;
    logic [RAM_AW-1:0] gnt_addr;
    logic              unused_addr_bits;

    assign d_req     = d_ren | d_wen;
    assign gnt_wr    = (gnt_port == PORT_D) && d_wen;
    assign gnt_addr  = (gnt_port == PORT_D) ? d_addr[RAM_AW+1:2] : i_addr[RAM_AW+1:2];
    assign dbg_state = state_q;

    // Byte-lane bits and bits above the RAM window are dropped, so addresses alias.
    assign unused_addr_bits = &{1'b0, i_addr[31:RAM_AW+2], i_addr[1:0],
                                d_addr[31:RAM_AW+2], d_addr[1:0]};

    mem_resp_arbiter u_arb (
        .clk       (clk),
        .nRST      (nRST),
        .idle      (state_q == IDLE),
        .i_req     (i_req),
        .d_req     (d_req),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = BUSY;
                    take    = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    done    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q     <= '0;
            port_q    <= PORT_I;
            op_q      <= OP_RD;
            ram_addr  <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (take) begin
                port_q   <= gnt_port;
                op_q     <= gnt_wr ? OP_WR : OP_RD;
                ram_addr <= gnt_addr;
                ram_ren  <= !gnt_wr;
                ram_wen  <= gnt_wr;
                cnt_q    <= CNT_LOAD;
                if (gnt_wr) begin
                    ram_wdata <= d_wdata;
                end
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Last BUSY edge: drop strobes, capture read data, raise the port's ready.
            if (done) begin
                ram_ren <= 1'b0;
                ram_wen <= 1'b0;
                i_ready <= (port_q == PORT_I);
                d_ready <= (port_q == PORT_D);
                if (op_q == OP_RD) begin
                    if (port_q == PORT_I) begin
                        i_rdata <= ram_rdata;
                    end else begin
                        d_rdata <= ram_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard queue of expected ready pulses plus a RAM model.
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int LATENCY = 2;
    localparam int RAM_AW  = 10;

    logic              clk, nRST;
    logic              i_req, d_ren, d_wen;
    logic [31:0]       i_addr, d_addr, d_wdata;
    logic [31:0]       i_rdata, d_rdata, ram_wdata, ram_rdata;
    logic              i_ready, d_ready, ram_ren, ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    state_t            dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Entry layout: {port (1 = data), ready cycle[15:0], data[31:0]}
    logic [48:0] exp_q[$];

    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic              pl_en;
    logic [RAM_AW-1:0] pl_addr;
    logic [31:0]       pl_data;
    bit                last_d;
    logic [31:0]       last_drd;

    mem_responder #(.LATENCY(LATENCY), .RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .ram_addr  (ram_addr),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / RAM model ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    assign ram_rdata = ram_ren ? mem[ram_addr] : 32'h0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input bit is_d, input int at, input logic [31:0] data);
        exp_q.push_back({is_d, 16'(at), data});
    endtask

    always @(negedge clk) begin
        logic [48:0] e;
        if (nRST && (i_ready || d_ready)) begin
            if (i_ready && d_ready) check("both_ready", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {i_ready, d_ready}, 0);
            end else begin
                e = exp_q.pop_front();
                check("ready_port", d_ready, e[48]);
                check("ready_cycle", cyc, e[47:32]);
                check("ready_data", e[48] ? d_rdata : i_rdata, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input bit is_d, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [RAM_AW-1:0] exp_raddr, input logic [31:0] exp_data,
                          input bit drop_early, input string name);
        int c;
        bit got;
        c = cyc;
        if (is_d) begin
            d_ren = rd; d_wen = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        expect_resp(is_d, c + LATENCY + 1, exp_data);
        @(posedge clk); #1;
        check({name, "_state"}, dbg_state, BUSY);
        check({name, "_addr"}, ram_addr, exp_raddr);
        check({name, "_strobes"}, {ram_ren, ram_wen}, (is_d && wr) ? 2'b01 : 2'b10);
        if (drop_early) begin
            i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            got = i_ready | d_ready;
            if (cyc == c + LATENCY) check({name, "_addr_hold"}, ram_addr, exp_raddr);
        end
        if (!got) check({name, "_timeout"}, 0, 1);
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        last_d = is_d;
        @(posedge clk); #1;
    endtask

    // Fetch of 0x10 and load of 0x40 requested together and held until served.
    task automatic contend(input string name);
        int c;
        bit first_d;
        c = cyc;
`ifdef MEM_RESP_FAIR_ARB_EN
        first_d = !last_d;
`else
        first_d = 1'b1;
`endif
        i_req = 1'b1; i_addr = 32'h10;
        d_ren = 1'b1; d_addr = 32'h40;
        if (first_d) begin
            expect_resp(1'b1, c + LATENCY + 1, 32'hDEAD_BEEF);
            expect_resp(1'b0, c + 2 * LATENCY + 3, 32'h0050_0093);
        end else begin
            expect_resp(1'b0, c + LATENCY + 1, 32'h0050_0093);
            expect_resp(1'b1, c + 2 * LATENCY + 3, 32'hDEAD_BEEF);
        end
        for (int k = 0; k < 30 && (i_req || d_ren); k++) begin
            @(posedge clk); #1;
            if (d_ready) d_ren = 1'b0;
            if (i_ready) i_req = 1'b0;
        end
        if (i_req || d_ren) check({name, "_timeout"}, 0, 1);
        i_req = 1'b0; d_ren = 1'b0;
        last_d = !first_d;
        last_drd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRST = 1'b0; i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        last_d = 1'b1; last_drd = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_flags", {ram_ren, ram_wen, i_ready, d_ready}, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);

        pl_en = 1'b1; pl_addr = 10'd4; pl_data = 32'h0050_0093;
        @(posedge clk); #1;
        pl_addr = 10'd0; pl_data = 32'h1111_1111;
        @(posedge clk); #1;
        pl_en = 1'b0;
        nRST = 1'b1;
        @(posedge clk); #1;

        run_op(0, 1, 0, 32'h10, 32'h0, 10'd4, 32'h0050_0093, 0, "fetch");
        run_op(1, 0, 1, 32'h40, 32'hDEAD_BEEF, 10'h10, last_drd, 0, "store");
        check("store_wdata", ram_wdata, 32'hDEAD_BEEF);
        run_op(1, 1, 0, 32'h40, 32'h0, 10'h10, 32'hDEAD_BEEF, 0, "load");
        last_drd = 32'hDEAD_BEEF;
        run_op(1, 1, 0, 32'h0000_1000, 32'h0, 10'h0, 32'h1111_1111, 0, "alias_hi");
        last_drd = 32'h1111_1111;
        run_op(1, 1, 0, 32'h43, 32'h0, 10'h10, 32'hDEAD_BEEF, 0, "alias_lo");
        last_drd = 32'hDEAD_BEEF;
        run_op(1, 1, 1, 32'h80, 32'hCAFE_F00D, 10'h20, last_drd, 1, "rw_both");
        run_op(1, 1, 0, 32'h80, 32'h0, 10'h20, 32'hCAFE_F00D, 0, "rw_readback");
        last_drd = 32'hCAFE_F00D;
        run_op(0, 1, 0, 32'h10, 32'h0, 10'd4, 32'h0050_0093, 1, "fetch_drop");
        contend("contend");

        // Reset in the middle of a fetch: no ready pulse, outputs clear at once.
        i_req = 1'b1; i_addr = 32'h10;
        @(posedge clk); #1;
        check("midrst_busy", {ram_ren, dbg_state}, {1'b1, BUSY});
        #2;
        nRST = 1'b0; i_req = 1'b0;
        #1;
        check("midrst_flags", {ram_ren, ram_wen, i_ready, d_ready}, 0);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_regs", {ram_addr, i_rdata, d_rdata}, 0);
        last_d = 1'b1;
        last_drd = '0;
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", {dbg_state, ram_ren, ram_wen}, {IDLE, 2'b00});
        contend("contend_rst");

        check("queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's instruction-fetch and data-access requests. It accepts level-held requests from the fetch port (PC side) and the load/store port (ALU-address side), arbitrates them onto one single-port synchronous RAM with a fixed read/write latency, and returns data with one-cycle `i_ready` / `d_ready` pulses. These pulses drive the core's PC enable and load/store completion.

## Interface
- `LATENCY`, default 2: RAM access latency in cycles; legal range ≥1.
- `RAM_AW`, default 10: RAM word-address width.
- `clk` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request, held high until `i_ready`.
- `i_addr` in 32: fetch byte address.
- `i_rdata` out 32: fetched instruction, valid when `i_ready`.
- `i_ready` out 1: one-cycle fetch-complete pulse.
- `d_ren` in 1: data read request, level.
- `d_wen` in 1: data write request, level.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data, valid when `d_ready`.
- `d_ready` out 1: one-cycle data-complete pulse.
- `ram_addr` out RAM_AW: RAM word address.
- `ram_ren` out 1: RAM read strobe.
- `ram_wen` out 1: RAM write strobe.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid LATENCY cycles after the strobe first asserts.

## Operation
- FSM states:
  - IDLE → BUSY on a grant.
  - BUSY → RESP when the counter reaches 0.
  - RESP → IDLE unconditionally.
- Arbitration happens only in IDLE. A data request (`d_ren | d_wen`) beats `i_req` (fixed priority).
- At grant, the following are registered: port, op, `ram_addr = addr[RAM_AW+1:2]`, and `ram_wdata`. Address bits [1:0] are ignored. Upper bits above RAM_AW+1 are ignored, so addresses alias/wrap.
- In BUSY, `ram_ren` or `ram_wen` is held high and `ram_addr` is stable. The down-counter loads LATENCY-1 at grant.
- `d_ren` & `d_wen` both high: treated as a write. `d_rdata` is unchanged.
- In RESP, exactly one of `i_ready` / `d_ready` is high. For reads, `ram_rdata` is captured at the last BUSY edge into `i_rdata` / `d_rdata`, which hold until the next read on that port.
- A write completes with a `d_ready` pulse; `d_rdata` is unchanged.
- Request inputs are sampled only at grant. Changes during BUSY/RESP are ignored.
- No new grant occurs in RESP. A request still high in RESP is re-arbitrated in the following IDLE cycle as a new transaction.

## Timing
- Request high in IDLE at cycle 0 → BUSY during cycles 1..LATENCY → ready pulse in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Maximum throughput is one transaction per LATENCY+2 cycles.
- Reset values: state IDLE; all outputs 0 (`ram_*`, `i_ready`, `d_ready`, `i_rdata`, `d_rdata`, `ram_addr`, `ram_wdata`).
- Reset mid-transaction: the transaction is dropped with no ready pulse. Strobes drop asynchronously. A RAM write already in flight may or may not commit.
- No combinational paths from inputs to outputs; every output is registered.

## Configuration
- `MEM_RESP_FAIR_ARB_EN` defined: round-robin arbitration. When both ports request in IDLE, the port not served in the last transaction wins. The last-served port resets to "data", so fetch wins the first tie.
- Undefined: fixed data-over-fetch priority as described above.

## Structure
- `mem_resp_pkg` holds:
  - the `state_t` enum (IDLE/BUSY/RESP),
  - the `port_t` enum (PORT_I/PORT_D),
  - the `op_t` enum (OP_RD/OP_WR),
  - the data-width constant (32).
- One sub-module, `mem_resp_arbiter`: combinational grant from the request lines, plus the last-served register when `MEM_RESP_FAIR_ARB_EN` is defined.
- FSM, counter and datapath registers live in `mem_responder`.

## Test plan
- Reset: assert `nRST`=0 mid-BUSY → all outputs 0 immediately; after release with no requests → outputs stay 0 and no ready pulses.
- Fetch, LATENCY=2: `i_req`=1, `i_addr`=0x0000_0010 at cycle 0 → `ram_ren`=1, `ram_addr`=4 in cycles 1–2; RAM returns 0x0050_0093 → `i_ready`=1 and `i_rdata`=0x0050_0093 in cycle 3 only.
- Store then load: `d_wen`, `d_addr`=0x40, `d_wdata`=0xDEAD_BEEF → `ram_wen`, `ram_addr`=0x10, `d_ready` pulse. Then `d_ren` at 0x40 → `d_rdata`=0xDEAD_BEEF.
- Contention: `i_req` and `d_ren` high together at cycle 0, both held:
  - Default build: `d_ready` in cycle 3, `i_ready` in cycle 7.
  - `MEM_RESP_FAIR_ARB_EN` build: `i_ready` first, then `d_ready`.
- Aliasing: `d_addr`=0x0000_1000 with RAM_AW=10 → `ram_addr`=0. `d_addr`=0x43 → `ram_addr`=0x10.
- `d_ren`=`d_wen`=1 → write performed and `d_rdata` unchanged. Deasserting the request during BUSY still yields a ready pulse in cycle LATENCY+1.
